// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcode/funct constants and instruction-class codes.
package mc_ctrl_fsm_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned INST_W  = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT = 4'd0,
    ST_IF   = 4'd1,
    ST_IW   = 4'd2,
    ST_ID   = 4'd3,
    ST_EX   = 4'd4,
    ST_ST   = 4'd5,
    ST_LD   = 4'd6,
    ST_RDW  = 4'd7,
    ST_WB   = 4'd8
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP    = 4'd0,
    CLS_ALU    = 4'd1,
    CLS_BRANCH = 4'd2,
    CLS_J      = 4'd3,
    CLS_JAL    = 4'd4,
    CLS_JR     = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LOAD   = 4'd7,
    CLS_STORE  = 4'd8
  } inst_class_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

endpackage

// File: rtl/mc_ctrl_fsm_inst_dec.sv
// Combinational instruction classifier: IR -> instruction class.
module mc_inst_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [INST_W-1:0] ir,
  output inst_class_e       cls_c
);

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = ir[31:26];
  assign funct = ir[5:0];

  // Map opcode (and funct for R-type) to a class; all-zero word and unknown opcodes are NOPs.
  always_comb begin
    cls_c = CLS_NOP;
    if (ir != '0) begin
      case (op)
        OP_RTYPE: begin
          if (funct == FN_JR)        cls_c = CLS_JR;
          else if (funct == FN_JALR) cls_c = CLS_JALR;
          else                       cls_c = CLS_ALU;
        end
        OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls_c = CLS_BRANCH;
        OP_J:   cls_c = CLS_J;
        OP_JAL: cls_c = CLS_JAL;
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI:            cls_c = CLS_ALU;
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:         cls_c = CLS_LOAD;
        OP_SB, OP_SH, OP_SW:                         cls_c = CLS_STORE;
        default: cls_c = CLS_NOP;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS controller: PC, IR and the IF/IW/ID/EX/ST/LD/RDW/WB sequencer
// with valid/ready handshakes to instruction and data memory.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  inst_req_valid,
  input  logic                  inst_req_ready,
  input  logic [INST_W-1:0]     instruction,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic                  rdata_valid,
  output logic                  rdata_ready,
  input  logic                  branch_taken,
  input  logic [31:0]           rs_data,
  input  logic                  mov_cond,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [INST_W-1:0]     ir,
  output logic                  ex_en,
  output logic                  reg_wen,
  output logic [STATE_W-1:0]    state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           inst_cnt,
  output logic [31:0]           mem_stall_cnt
`endif
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic                  ir_load;
  logic                  wb_q;
  inst_class_e           cls;
  logic [ADDR_WIDTH-1:0] pc4, br_tgt, j_tgt;
  logic [31:0]           br_off, pc4_ext, j_tgt_ext;

  mc_inst_dec u_dec (
    .ir    (ir),
    .cls_c (cls)
  );

  // PC arithmetic wraps naturally at ADDR_WIDTH bits.
  assign pc4       = pc + ADDR_WIDTH'(4);
  assign br_off    = {{14{ir[15]}}, ir[15:0], 2'b00};
  assign br_tgt    = pc4 + ADDR_WIDTH'(br_off);
  assign pc4_ext   = 32'(pc4);
  assign j_tgt_ext = {pc4_ext[31:28], ir[25:0], 2'b00};
  assign j_tgt     = ADDR_WIDTH'(j_tgt_ext);

  // Next-state and next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    ir_load = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_IF;
      ST_IF:   if (inst_req_ready) state_d = ST_IW;
      ST_IW: begin
        if (inst_valid) begin
          ir_load = 1'b1;
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        if (cls == CLS_NOP) begin
          pc_d    = pc4;
          state_d = ST_IF;
        end else begin
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        pc_d    = pc4;
        state_d = ST_WB;
        case (cls)
          CLS_BRANCH: begin pc_d = branch_taken ? br_tgt : pc4;  state_d = ST_IF; end
          CLS_J:      begin pc_d = j_tgt;                        state_d = ST_IF; end
          CLS_JAL:    begin pc_d = j_tgt;                        state_d = ST_WB; end
          CLS_JR:     begin pc_d = ADDR_WIDTH'(rs_data);         state_d = ST_IF; end
          CLS_JALR:   begin pc_d = ADDR_WIDTH'(rs_data);         state_d = ST_WB; end
          CLS_LOAD:   state_d = ST_LD;
          CLS_STORE:  state_d = ST_ST;
          default:    state_d = ST_WB;
        endcase
      end
      ST_ST:   if (mem_req_ready) state_d = ST_IF;
      ST_LD:   if (mem_req_ready) state_d = ST_RDW;
      ST_RDW:  if (rdata_valid)   state_d = ST_WB;
      ST_WB:   state_d = ST_IF;
      default: state_d = ST_INIT;
    endcase
  end

  // State, PC, IR and per-state outputs, registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_INIT;
      pc             <= RESET_PC[ADDR_WIDTH-1:0];
      ir             <= '0;
      inst_req_valid <= 1'b0;
      inst_ready     <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      rdata_ready    <= 1'b0;
      ex_en          <= 1'b0;
      wb_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc             <= pc_d;
      if (ir_load) ir <= instruction;
      inst_req_valid <= (state_d == ST_IF);
      inst_ready     <= (state_d == ST_IW);
      mem_req_valid  <= (state_d == ST_ST) || (state_d == ST_LD);
      mem_rd         <= (state_d == ST_LD);
      mem_wr         <= (state_d == ST_ST);
      rdata_ready    <= (state_d == ST_RDW);
      ex_en          <= (state_d == ST_EX);
      wb_q           <= (state_d == ST_WB);
    end
  end

  // The MOVZ/MOVN condition arrives from the datapath during WB itself.
  assign reg_wen = wb_q & mov_cond;
  assign state   = state_q;

`ifdef PERF_CNT_EN
  logic stall;

  assign stall = ((state_q == ST_IF)  && !inst_req_ready) ||
                 ((state_q == ST_IW)  && !inst_valid)     ||
                 ((state_q == ST_ST)  && !mem_req_ready)  ||
                 ((state_q == ST_LD)  && !mem_req_ready)  ||
                 ((state_q == ST_RDW) && !rdata_valid);

  // Free-running wrapping performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt     <= '0;
      inst_cnt      <= '0;
      mem_stall_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if ((state_q == ST_ID) && (ir != '0)) inst_cnt <= inst_cnt + 32'd1;
      if (stall) mem_stall_cnt <= mem_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
